// File: rtl/costas_fir_sched_if.sv
// Mixer-side and coefficient-ROM signal bundle for costas_fir_sched.
// master drives samples, ROM data and clr_ovr; slave is the scheduler.
interface costas_fir_sched_if #(
    parameter int DW = 32,
    parameter int CW = 10,
    parameter int AW = 6
);
    logic                 push_in;
    logic signed [DW-1:0] samp_i;
    logic signed [DW-1:0] samp_q;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 busy;
    logic                 push_out;
    logic signed [DW-1:0] fir_i;
    logic signed [DW-1:0] fir_q;
    logic                 overrun;
    logic                 clr_ovr;

    modport master (
        output push_in, samp_i, samp_q, coef_data, clr_ovr,
        input  coef_addr, busy, push_out, fir_i, fir_q, overrun
    );

    modport slave (
        input  push_in, samp_i, samp_q, coef_data, clr_ovr,
        output coef_addr, busy, push_out, fir_i, fir_q, overrun
    );
endinterface

// File: rtl/costas_fir_sched.sv
// Time-multiplexed I/Q FIR: one shared MAC sweeps the I taps, then the Q taps.
// Define COSTAS_FIR_SAT_EN to saturate the accumulators instead of wrapping.
module costas_fir_sched #(
    parameter int NTAPS = 43,
    parameter int DW    = 32,
    parameter int CW    = 10,
    parameter int AW    = 6,
    parameter int SHIFT = 10
) (
    input logic               clk,
    input logic               reset,
    costas_fir_sched_if.slave bus
);
    localparam int PW = DW + CW;
    localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);
    localparam logic signed [PW-1:0] Bias = PW'((64'd1 << SHIFT) - 64'd1);

    typedef enum logic [1:0] {StIdle, StMacI, StMacQ} state_t;

    state_t               r_state;
    logic [AW-1:0]        r_idx;
    logic signed [DW-1:0] r_acc_i, r_acc_q;
    logic signed [DW-1:0] r_fir_i, r_fir_q;
    logic                 r_push_out, r_busy, r_overrun;
    logic signed [DW-1:0] r_line_i [NTAPS];
    logic signed [DW-1:0] r_line_q [NTAPS];

    logic signed [DW-1:0] w_samp, w_acc, w_term, w_sum;
    logic signed [PW-1:0] w_prod, w_adj;
    logic                 w_last;

    always_comb begin
        w_samp = (r_state == StMacQ) ? r_line_q[r_idx] : r_line_i[r_idx];
        w_acc  = (r_state == StMacQ) ? r_acc_q : r_acc_i;
        w_prod = w_samp * bus.coef_data;
        // Bias negatives so the arithmetic shift rounds toward zero.
        w_adj  = w_prod + (w_prod[PW-1] ? Bias : '0);
        w_term = DW'(w_adj >>> SHIFT);
        w_last = (r_idx == LastIdx);
    end

`ifdef COSTAS_FIR_SAT_EN
    localparam logic signed [DW-1:0] SatMax = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SatMin = {1'b1, {(DW-1){1'b0}}};
    logic signed [DW:0] w_wide;

    always_comb begin
        w_wide = {w_acc[DW-1], w_acc} + {w_term[DW-1], w_term};
        if (w_wide[DW] != w_wide[DW-1]) begin
            w_sum = w_wide[DW] ? SatMin : SatMax;
        end else begin
            w_sum = w_wide[DW-1:0];
        end
    end
`else
    always_comb begin
        w_sum = w_acc + w_term;
    end
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_fir_i    <= '0;
            r_fir_q    <= '0;
            r_push_out <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_line_i[k] <= '0;
                r_line_q[k] <= '0;
            end
        end else begin
            r_push_out <= 1'b0;
            // A drop outranks a same-edge clear.
            if (bus.push_in && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.push_in) begin
                        r_line_i[0] <= bus.samp_i;
                        r_line_q[0] <= bus.samp_q;
                        for (int k = NTAPS - 1; k > 0; k--) begin
                            r_line_i[k] <= r_line_i[k-1];
                            r_line_q[k] <= r_line_q[k-1];
                        end
                        r_idx   <= '0;
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StMacI;
                    end
                end
                StMacI: begin
                    r_acc_i <= w_sum;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= StMacQ;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                StMacQ: begin
                    r_acc_q <= w_sum;
                    if (w_last) begin
                        r_fir_i    <= r_acc_i;
                        r_fir_q    <= w_sum;
                        r_push_out <= 1'b1;
                        r_busy     <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= StIdle;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.coef_addr = r_idx;
    assign bus.busy      = r_busy;
    assign bus.push_out  = r_push_out;
    assign bus.fir_i     = r_fir_i;
    assign bus.fir_q     = r_fir_q;
    assign bus.overrun   = r_overrun;
endmodule
